led_scan_ctrl: RTL

- Time-multiplexed chip-select generator for an N-digit 7-segment LED bank.
- Cycles a digit pointer at a programmable slot rate and inserts a blanking gap before each digit to remove ghosting.
- Skips digits that are masked off and supports either chip-select polarity.
- Sits between the display data path, which reads cs_ptr to select segment data, and the board digit drivers.

---
 rtl/led_pkg.sv | 24 ++
 rtl/led_next_ptr.sv | 39 +++
 rtl/led_scan_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/led_pkg.sv
// ---------------------------------------------------------------------------
// led_pkg
// Shared types and helpers for the LED digit-scan controller.
//   scan_state_t  : scan FSM states (IDLE, BLANK, ON)
//   CS_MAX_W      : widest chip-select bank the helper below can describe
//   cs_inactive() : all-lines-inactive chip-select pattern for a polarity;
//                   callers keep the low N_DIGITS bits
// ---------------------------------------------------------------------------
package led_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        ON    = 2'd2
    } scan_state_t;

    localparam int CS_MAX_W = 64;

    // Active-high banks idle at all zeros, active-low banks at all ones.
    function automatic logic [CS_MAX_W-1:0] cs_inactive(input bit active_high);
        return active_high ? {CS_MAX_W{1'b0}} : {CS_MAX_W{1'b1}};
    endfunction

endpackage

// File: rtl/led_next_ptr.sv
// ---------------------------------------------------------------------------
// led_next_ptr
// Combinational wrapping priority search for the next enabled digit.
//   cur_ptr    in  PTR_W     search starts at cur_ptr+1 (mod N_DIGITS)
//   digit_mask in  N_DIGITS  1 = digit takes part in the scan
//   nxt_ptr    out PTR_W     first enabled index found (cur_ptr if none)
//   wrapped    out 1         nxt_ptr <= cur_ptr, i.e. the scan went round
//   any_en     out 1         at least one digit is enabled
// Passing cur_ptr = N_DIGITS-1 yields the lowest enabled digit.
// ---------------------------------------------------------------------------
module led_next_ptr
    import led_pkg::*;
#(
    parameter int N_DIGITS = 8,
    parameter int PTR_W    = $clog2(N_DIGITS)
) (
    input  logic [PTR_W-1:0]    cur_ptr,
    input  logic [N_DIGITS-1:0] digit_mask,
    output logic [PTR_W-1:0]    nxt_ptr,
    output logic                wrapped,
    output logic                any_en
);

    // Walk the distances from farthest to nearest so the nearest enabled
    // digit is the last one written and therefore wins. Distance N_DIGITS
    // lands back on cur_ptr, covering the single-enabled-digit case.
    always_comb begin
        nxt_ptr = cur_ptr;
        for (int step = N_DIGITS; step >= 1; step--) begin
            if (digit_mask[(int'(cur_ptr) + step) % N_DIGITS]) begin
                nxt_ptr = PTR_W'((int'(cur_ptr) + step) % N_DIGITS);
            end
        end
    end

    assign any_en  = |digit_mask;
    assign wrapped = any_en && (nxt_ptr <= cur_ptr);

endmodule

// File: rtl/led_scan_ctrl.sv
// ---------------------------------------------------------------------------
// led_scan_ctrl
// Time-multiplexed chip-select generator for an N-digit 7-segment bank.
// Each slot is SLOT_CYC cycles: BLANK_CYC blank cycles, then the selected
// digit is driven for the rest of the slot. Masked-off digits are skipped.
//   clk        in  1         system clock
//   rst_n      in  1         synchronous, active-low reset
//   en         in  1         scan enable
//   digit_mask in  N_DIGITS  1 = digit participates in the scan
//   cs         out N_DIGITS  registered one-hot chip-select (active polarity)
//   cs_ptr     out PTR_W     current/upcoming digit index for the segment mux
//   slot_start out 1         pulse on the first cycle of every slot
//   frame_done out 1         pulse when the pointer wraps to the lowest digit
// ---------------------------------------------------------------------------
module led_scan_ctrl
    import led_pkg::*;
#(
    parameter int N_DIGITS       = 8,
    parameter int SLOT_CYC       = 50000,
    parameter int BLANK_CYC      = 16,
    parameter int CS_ACTIVE_HIGH = 1,
    parameter int PTR_W          = $clog2(N_DIGITS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [N_DIGITS-1:0] digit_mask,
    output logic [N_DIGITS-1:0] cs,
    output logic [PTR_W-1:0]    cs_ptr,
    output logic                slot_start,
    output logic                frame_done
);

    localparam int CNT_W = $clog2(SLOT_CYC + 1);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SLOT_CYC - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
    localparam logic [CS_MAX_W-1:0] CS_OFF_W = cs_inactive(CS_ACTIVE_HIGH != 0);
    localparam logic [N_DIGITS-1:0] CS_OFF   = CS_OFF_W[N_DIGITS-1:0];
    localparam scan_state_t SLOT_ENTRY = (BLANK_CYC == 0) ? ON : BLANK;

    scan_state_t         state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [N_DIGITS-1:0] cs_q, cs_d;
    logic                slot_start_q, slot_start_d;
    logic                frame_done_q, frame_done_d;

    logic [PTR_W-1:0]    srch_cur;
    logic [PTR_W-1:0]    srch_ptr;
    logic                srch_wrap;
    logic                srch_any;

    // From IDLE the search starts just past the top digit so it returns
    // the lowest enabled digit; otherwise it advances from the live pointer.
    assign srch_cur = (state_q == IDLE) ? PTR_W'(N_DIGITS - 1) : ptr_q;

    led_next_ptr #(
        .N_DIGITS (N_DIGITS),
        .PTR_W    (PTR_W)
    ) u_next_ptr (
        .cur_ptr    (srch_cur),
        .digit_mask (digit_mask),
        .nxt_ptr    (srch_ptr),
        .wrapped    (srch_wrap),
        .any_en     (srch_any)
    );

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            ptr_q        <= '0;
            cs_q         <= CS_OFF;
            slot_start_q <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ptr_q        <= ptr_d;
            cs_q         <= cs_d;
            slot_start_q <= slot_start_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Next-state, counter and pointer logic. digit_mask only matters on the
    // IDLE start and at the last cycle of a slot, so mid-slot changes are
    // ignored by construction. A dropped enable overrides a slot boundary.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ptr_d        = ptr_q;
        slot_start_d = 1'b0;
        frame_done_d = 1'b0;
        if (!en) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    if (srch_any) begin
                        ptr_d        = srch_ptr;
                        slot_start_d = 1'b1;
                        state_d      = SLOT_ENTRY;
                    end
                end
                BLANK: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == BLANK_LAST) begin
                        state_d = ON;
                    end
                end
                ON: begin
                    if (cnt_q == SLOT_LAST) begin
                        cnt_d = '0;
                        if (srch_any) begin
                            ptr_d        = srch_ptr;
                            slot_start_d = 1'b1;
                            frame_done_d = srch_wrap;
                            state_d      = SLOT_ENTRY;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Chip-select decode from the next state so cs lines up with ON cycles.
    // Pointer codes past N_DIGITS-1 match no line and leave cs inactive;
    // XOR with the idle pattern applies the bank polarity.
    always_comb begin
        cs_d = '0;
        if (state_d == ON) begin
            for (int i = 0; i < N_DIGITS; i++) begin
                cs_d[i] = (ptr_d == PTR_W'(i));
            end
        end
        cs_d = cs_d ^ CS_OFF;
    end

    assign cs         = cs_q;
    assign cs_ptr     = ptr_q;
    assign slot_start = slot_start_q;
    assign frame_done = frame_done_q;

endmodule
